// File: rtl/bcd_timer_chain.sv
// -----------------------------------------------------------------------------
// bcd_timer_chain
//   N-digit BCD up/down timer with a per-digit modulus, for mm:ss:cc style
//   displays. A small IDLE/RUN/DONE FSM provides stop-at-terminal or wrap
//   behaviour. It is advanced by a shared 10 ms tick strobe.
//
// Ports
//   clk_i          system clock
//   rst_ni         asynchronous active-low reset
//   tick_i         1-cycle count strobe
//   run_i          level: 1 = count, 0 = pause
//   up_i           direction: 1 = up, 0 = down
//   load_i         1-cycle synchronous load strobe (highest priority)
//   load_val_i     load value, digit i at [4i+3:4i]; clamped to DIGIT_MAX
//   digits_o       current count, same packing
//   at_terminal_o  up: all digits at max; down: all digits zero
//   running_o      FSM in RUN
//   done_o         FSM in DONE
//   wrap_pulse_o   1-cycle pulse after a terminal rollover (wrap mode only)
// -----------------------------------------------------------------------------
module bcd_timer_chain #(
  parameter int unsigned               NUM_DIGITS  = 4,
  parameter logic [4*NUM_DIGITS-1:0]   DIGIT_MAX   = {NUM_DIGITS{4'd9}},
  parameter bit                        STOP_AT_END = 1'b1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      tick_i,
  input  logic                      run_i,
  input  logic                      up_i,
  input  logic                      load_i,
  input  logic [4*NUM_DIGITS-1:0]   load_val_i,
  output logic [4*NUM_DIGITS-1:0]   digits_o,
  output logic                      at_terminal_o,
  output logic                      running_o,
  output logic                      done_o,
  output logic                      wrap_pulse_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e                         state_q, state_d;
  logic [NUM_DIGITS-1:0][3:0]     cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0][3:0]     cnt_step;    // count after one step
  logic [NUM_DIGITS-1:0][3:0]     load_clamp;
  logic [NUM_DIGITS-1:0]          roll;        // digit sits at its rollover value
  logic [NUM_DIGITS-1:0]          carry;       // digit is allowed to step
  logic [NUM_DIGITS-1:0]          nxt_max, nxt_zero;
  logic                           at_terminal, nxt_terminal;
  logic                           wrap_q, wrap_d;

  // Per-digit ripple step and load clamp
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    localparam logic [3:0] MAX = DIGIT_MAX[4*g +: 4];
    logic at_max, at_zero;
    logic [3:0] lv;

    assign at_max  = (cnt_q[g] == MAX);
    assign at_zero = (cnt_q[g] == 4'd0);
    assign roll[g] = up_i ? at_max : at_zero;

    if (g == 0) begin : g_lsd
      assign carry[g] = 1'b1;
    end else begin : g_upper
      assign carry[g] = carry[g-1] & roll[g-1];
    end

    always_comb begin
      cnt_step[g] = cnt_q[g];
      if (carry[g]) begin
        if (up_i) cnt_step[g] = at_max  ? 4'd0 : cnt_q[g] + 4'd1;
        else      cnt_step[g] = at_zero ? MAX  : cnt_q[g] - 4'd1;
      end
    end

    assign nxt_max[g]  = (cnt_step[g] == MAX);
    assign nxt_zero[g] = (cnt_step[g] == 4'd0);

    // Non-BCD nibbles (A-F) are above every legal max, so they clamp too
    assign lv            = load_val_i[4*g +: 4];
    assign load_clamp[g] = (lv > MAX) ? MAX : lv;
  end

  assign at_terminal  = &roll;
  // Terminal test on the post-step value, so stop mode halts without overshoot
  assign nxt_terminal = up_i ? (&nxt_max) : (&nxt_zero);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    if (load_i) begin
      cnt_d   = load_clamp;
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (run_i) state_d = (STOP_AT_END && at_terminal) ? S_DONE : S_RUN;
        end
        S_RUN: begin
          if (!run_i) begin
            state_d = S_IDLE;
          end else if (tick_i) begin
            if (STOP_AT_END) begin
              // Direction flips can leave RUN sitting on a terminal: freeze there
              if (at_terminal) begin
                state_d = S_DONE;
              end else begin
                cnt_d = cnt_step;
                if (nxt_terminal) state_d = S_DONE;
              end
            end else begin
              cnt_d  = cnt_step;
              wrap_d = at_terminal;
            end
          end
        end
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
    end
  end

  assign digits_o      = cnt_q;
  assign at_terminal_o = at_terminal;
  assign running_o     = (state_q == S_RUN);
  assign done_o        = (state_q == S_DONE);
  assign wrap_pulse_o  = wrap_q;

endmodule

// File: tb/tb_bcd_timer_chain.sv
// -----------------------------------------------------------------------------
// tb_bcd_timer_chain
//   Three instances share one stimulus stream: stop mode with 9999 max, stop
//   mode with {5,9,9,9} max, and wrap mode with 9999 max. The reference model
//   holds each count as a mixed-radix integer and steps it with +/-1 modulo
//   the total range.
// -----------------------------------------------------------------------------
module tb_bcd_timer_chain;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tick, run, up, load;
  logic [15:0] lv;

  logic [15:0] dig  [3];
  logic        term [3];
  logic        runn [3];
  logic        dn   [3];
  logic        wp   [3];

  int tests = 0;
  int fails = 0;

  int mval [3];
  bit mrun [3], mdone [3], mwrap [3];

  always #5 clk = ~clk;

  bcd_timer_chain #(.NUM_DIGITS(4), .DIGIT_MAX(16'h9999), .STOP_AT_END(1'b1)) dut_s (
    .clk_i(clk), .rst_ni(rst_n), .tick_i(tick), .run_i(run), .up_i(up), .load_i(load),
    .load_val_i(lv), .digits_o(dig[0]), .at_terminal_o(term[0]), .running_o(runn[0]),
    .done_o(dn[0]), .wrap_pulse_o(wp[0]));

  bcd_timer_chain #(.NUM_DIGITS(4), .DIGIT_MAX(16'h5999), .STOP_AT_END(1'b1)) dut_m (
    .clk_i(clk), .rst_ni(rst_n), .tick_i(tick), .run_i(run), .up_i(up), .load_i(load),
    .load_val_i(lv), .digits_o(dig[1]), .at_terminal_o(term[1]), .running_o(runn[1]),
    .done_o(dn[1]), .wrap_pulse_o(wp[1]));

  bcd_timer_chain #(.NUM_DIGITS(4), .DIGIT_MAX(16'h9999), .STOP_AT_END(1'b0)) dut_w (
    .clk_i(clk), .rst_ni(rst_n), .tick_i(tick), .run_i(run), .up_i(up), .load_i(load),
    .load_val_i(lv), .digits_o(dig[2]), .at_terminal_o(term[2]), .running_o(runn[2]),
    .done_o(dn[2]), .wrap_pulse_o(wp[2]));

  // ---------------- reference model ----------------
  function automatic int dmax(int k, int i);
    logic [15:0] m;
    m = (k == 1) ? 16'h5999 : 16'h9999;
    return int'(m[4*i +: 4]);
  endfunction

  function automatic bit stop_mode(int k);
    return k != 2;
  endfunction

  function automatic int total(int k);
    int t = 1;
    for (int i = 0; i < 4; i++) t = t * (dmax(k, i) + 1);
    return t;
  endfunction

  function automatic int to_int(int k, logic [15:0] d);
    int v = 0;
    int w = 1;
    for (int i = 0; i < 4; i++) begin
      int n = int'(d[4*i +: 4]);
      if (n > dmax(k, i)) n = dmax(k, i);   // load clamp
      v = v + n * w;
      w = w * (dmax(k, i) + 1);
    end
    return v;
  endfunction

  function automatic logic [15:0] to_dig(int k, int v);
    logic [15:0] d;
    int r;
    int x = v;
    d = '0;
    for (int i = 0; i < 4; i++) begin
      r = x % (dmax(k, i) + 1);
      d[4*i +: 4] = r[3:0];
      x = x / (dmax(k, i) + 1);
    end
    return d;
  endfunction

  function automatic bit is_term(int k, int v, bit u);
    return u ? (v == total(k) - 1) : (v == 0);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mval[k] = 0; mrun[k] = 0; mdone[k] = 0; mwrap[k] = 0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      mwrap[k] = 0;
      if (load) begin
        mval[k] = to_int(k, lv); mrun[k] = 0; mdone[k] = 0;
      end else if (mdone[k]) begin
        // frozen
      end else if (!mrun[k]) begin
        if (run) begin
          if (stop_mode(k) && is_term(k, mval[k], up)) mdone[k] = 1;
          else mrun[k] = 1;
        end
      end else if (!run) begin
        mrun[k] = 0;
      end else if (tick) begin
        if (stop_mode(k) && is_term(k, mval[k], up)) begin
          mrun[k] = 0; mdone[k] = 1;
        end else begin
          mwrap[k] = !stop_mode(k) && is_term(k, mval[k], up);
          mval[k]  = up ? (mval[k] + 1) % total(k) : (mval[k] + total(k) - 1) % total(k);
          if (stop_mode(k) && is_term(k, mval[k], up)) begin
            mrun[k] = 0; mdone[k] = 1;
          end
        end
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(string tag, int k, logic [15:0] obs, logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s[dut%0d] observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      chk("digits",   k, dig[k], to_dig(k, mval[k]));
      chk("at_term",  k, 16'(term[k]), 16'(is_term(k, mval[k], up)));
      chk("running",  k, 16'(runn[k]), 16'(mrun[k]));
      chk("done",     k, 16'(dn[k]),   16'(mdone[k]));
      chk("wrap",     k, 16'(wp[k]),   16'(mwrap[k]));
    end
  endtask

  // One clock: drive, edge, model, sample 1 time unit later
  task automatic cyc(bit l, logic [15:0] v, bit r, bit u, bit t);
    load = l; lv = v; run = r; up = u; tick = t;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  logic [15:0] picks [6];

  initial begin
    picks[0] = 16'h9999; picks[1] = 16'h0000; picks[2] = 16'h5999;
    picks[3] = 16'h0001; picks[4] = 16'h9998; picks[5] = 16'h0000;
    rst_n = 1'b0; tick = 0; run = 0; up = 1; load = 0; lv = '0;
    model_reset();
    #2;
    check_all();                               // reset state
    #10 rst_n = 1'b1;

    // 1. asynchronous reset mid-count
    cyc(1, 16'h1234, 0, 1, 0);
    cyc(0, 16'h0, 1, 1, 0);
    cyc(0, 16'h0, 1, 1, 1);
    cyc(0, 16'h0, 1, 1, 0);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    chk("async_rst_dig", 0, dig[0], 16'h0000);
    chk("async_rst_run", 0, 16'(runn[0]), 16'h0);
    @(negedge clk) rst_n = 1'b1;

    // 2. up ripple with {5,9,9,9}; then stuck at 5999 in stop mode
    cyc(1, 16'h0999, 0, 1, 0);
    cyc(0, 16'h0, 1, 1, 0);
    cyc(0, 16'h0, 1, 1, 1);
    chk("ripple", 1, dig[1], 16'h1000);
    cyc(1, 16'h5999, 0, 1, 0);
    cyc(0, 16'h0, 1, 1, 0);
    cyc(0, 16'h0, 1, 1, 1);
    chk("max_hold", 1, dig[1], 16'h5999);
    chk("max_done", 1, 16'(dn[1]), 16'h1);

    // 3. stop-mode count down to zero
    cyc(1, 16'h0002, 0, 0, 0);
    cyc(0, 16'h0, 1, 0, 0);
    cyc(0, 16'h0, 1, 0, 1);
    chk("down1", 0, dig[0], 16'h0001);
    cyc(0, 16'h0, 1, 0, 1);
    chk("down0", 0, dig[0], 16'h0000);
    chk("down_done", 0, 16'(dn[0]), 16'h1);
    cyc(0, 16'h0, 1, 0, 1);
    cyc(0, 16'h0, 1, 0, 1);
    chk("down_hold", 0, dig[0], 16'h0000);

    // 4. wrap mode up rollover
    cyc(1, 16'h9999, 0, 1, 0);
    cyc(0, 16'h0, 1, 1, 0);
    cyc(0, 16'h0, 1, 1, 1);
    chk("wrap_dig", 2, dig[2], 16'h0000);
    chk("wrap_pulse", 2, 16'(wp[2]), 16'h1);
    chk("wrap_run", 2, 16'(runn[2]), 16'h1);
    cyc(0, 16'h0, 1, 1, 0);
    chk("wrap_1cyc", 2, 16'(wp[2]), 16'h0);

    // 5. load/tick collision with clamp
    cyc(1, 16'h0042, 0, 1, 0);
    cyc(0, 16'h0, 1, 1, 0);
    cyc(1, 16'h0A07, 1, 1, 1);
    chk("collide", 0, dig[0], 16'h0907);
    chk("collide_idle", 0, 16'(runn[0]), 16'h0);

    // 6. pause, then count down
    cyc(1, 16'h0010, 0, 1, 0);
    cyc(0, 16'h0, 1, 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 16'h0, 0, 1, 1);
    chk("pause", 0, dig[0], 16'h0010);
    cyc(0, 16'h0, 1, 0, 0);
    cyc(0, 16'h0, 1, 0, 1);
    chk("dir_down", 0, dig[0], 16'h0009);

    // Randomised traffic against the model
    for (int n = 0; n < 800; n++) begin
      bit          l, r, u, t;
      logic [15:0] v;
      l = ($urandom_range(0, 15) == 0);
      r = ($urandom_range(0, 7) != 0);
      u = ($urandom_range(0, 7) == 0) ? ~up : up;
      t = $urandom_range(0, 1) == 1;
      v = ($urandom_range(0, 1) == 1) ? 16'($urandom) : picks[$urandom_range(0, 5)];
      cyc(l, v, r, u, t);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
